// File: rtl/ccu_snoop_pkg.sv
// Shared types, CR bit positions, AC snoop opcodes and the snoop decode
// used by the ACE snoop responder.
package ccu_snoop_pkg;

  localparam int unsigned CcuLineWidth    = 128;
  localparam int unsigned CcuAxiDataWidth = 64;
  localparam int unsigned CcuAddrWidth    = 64;

  localparam int unsigned CR_DT  = 0;
  localparam int unsigned CR_ERR = 1;
  localparam int unsigned CR_PD  = 2;
  localparam int unsigned CR_IS  = 3;
  localparam int unsigned CR_WU  = 4;

  localparam logic [3:0] SNP_READ_ONCE             = 4'b0000;
  localparam logic [3:0] SNP_READ_SHARED           = 4'b0001;
  localparam logic [3:0] SNP_READ_CLEAN            = 4'b0010;
  localparam logic [3:0] SNP_READ_NOT_SHARED_DIRTY = 4'b0011;
  localparam logic [3:0] SNP_READ_UNIQUE           = 4'b0111;
  localparam logic [3:0] SNP_CLEAN_SHARED          = 4'b1000;
  localparam logic [3:0] SNP_CLEAN_INVALID         = 4'b1001;
  localparam logic [3:0] SNP_MAKE_INVALID          = 4'b1101;

  typedef enum logic [1:0] {KEEP, SHARE, CLEAN, INVALIDATE} snoop_lookup_op_e;

  typedef struct packed {
    logic [CcuAddrWidth-1:0] addr;
    logic [3:0]              snoop;
  } ac_chan_t;

  typedef struct packed {
    logic [CcuAxiDataWidth-1:0] data;
    logic                       last;
  } cd_chan_t;

  typedef struct packed {
    ac_chan_t ac;
    logic     ac_valid;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic       ac_ready;
    logic       cr_valid;
    logic [4:0] cr_resp;
    logic       cd_valid;
    cd_chan_t   cd;
  } snoop_resp_t;

  typedef struct packed {
    snoop_lookup_op_e op;
    logic [4:0]       cr_resp;
    logic             supported;
  } snoop_decode_t;

  function automatic snoop_decode_t decode_snoop(input logic [3:0] snoop, input logic hit,
                                                 input logic dirty, input logic shared);
    snoop_decode_t d;
    d.op        = KEEP;
    d.cr_resp   = '0;
    d.supported = 1'b1;
    case (snoop)
      SNP_READ_ONCE: begin
        d.cr_resp[CR_DT] = 1'b1;
        d.cr_resp[CR_IS] = 1'b1;
      end
      SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NOT_SHARED_DIRTY: begin
        d.op             = SHARE;
        d.cr_resp[CR_DT] = 1'b1;
        d.cr_resp[CR_IS] = 1'b1;
        d.cr_resp[CR_PD] = dirty;
      end
      SNP_READ_UNIQUE: begin
        d.op             = INVALIDATE;
        d.cr_resp[CR_DT] = 1'b1;
        d.cr_resp[CR_PD] = dirty;
      end
      SNP_CLEAN_SHARED: begin
        d.op             = CLEAN;
        d.cr_resp[CR_DT] = dirty;
        d.cr_resp[CR_PD] = dirty;
        d.cr_resp[CR_IS] = 1'b1;
      end
      SNP_CLEAN_INVALID: begin
        d.op             = INVALIDATE;
        d.cr_resp[CR_DT] = dirty;
        d.cr_resp[CR_PD] = dirty;
      end
      SNP_MAKE_INVALID: d.op = INVALIDATE;
      default:          d.supported = 1'b0;
    endcase
    // Unsupported opcodes never reach the cache, so hit state is irrelevant there.
    if (!d.supported) begin
      d.cr_resp         = '0;
      d.cr_resp[CR_ERR] = 1'b1;
    end else if (!hit) begin
      d.cr_resp = '0;
    end else begin
      d.cr_resp[CR_WU] = !shared;
    end
    return d;
  endfunction

endpackage

// File: rtl/snoop_cd_serializer.sv
// Holds one cache line and streams it out as CD beats, low beat first,
// flagging the final beat with last.
module snoop_cd_serializer #(
  parameter int unsigned BeatWidth = 64,
  parameter int unsigned Words     = 2,
  parameter int unsigned BeatBits  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [BeatWidth*Words-1:0]     in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [BeatWidth-1:0]           out_data,
  output logic                           out_last
);

  localparam int unsigned LineWidth = BeatWidth * Words;
  localparam logic [BeatBits-1:0] LastBeat = BeatBits'(Words - 1);

  logic [LineWidth-1:0] line_reg;
  logic [BeatBits-1:0]  beat_reg;
  logic                 active_reg;
  logic [BeatWidth-1:0] beats [Words];

  genvar gi;
  generate
    for (gi = 0; gi < Words; gi++) begin : g_beat
      assign beats[gi] = line_reg[gi*BeatWidth +: BeatWidth];
    end
  endgenerate

  assign in_ready  = !active_reg;
  assign out_valid = active_reg;
  assign out_data  = beats[beat_reg];
  assign out_last  = (beat_reg == LastBeat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_reg   <= '0;
      beat_reg   <= '0;
      active_reg <= 1'b0;
    end else if (in_valid && in_ready) begin
      line_reg   <= in_data;
      beat_reg   <= '0;
      active_reg <= 1'b1;
    end else if (out_valid && out_ready) begin
      if (out_last) begin
        active_reg <= 1'b0;
        beat_reg   <= '0;
      end else begin
        beat_reg <= beat_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccu_snoop_responder.sv
// ACE snoop responder: takes one AC snoop, queries the L1 data cache,
// answers on CR and streams the line on CD when data transfer is needed.
module ccu_snoop_responder #(
  parameter int unsigned DcacheLineWidth = ccu_snoop_pkg::CcuLineWidth,
  parameter int unsigned AxiDataWidth    = ccu_snoop_pkg::CcuAxiDataWidth,
  parameter int unsigned AddrWidth       = ccu_snoop_pkg::CcuAddrWidth,
  parameter type snoop_req_t             = ccu_snoop_pkg::snoop_req_t,
  parameter type snoop_resp_t            = ccu_snoop_pkg::snoop_resp_t
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  snoop_req_t                       snoop_req_i,
  output snoop_resp_t                      snoop_resp_o,
  output logic                             lookup_req_o,
  input  logic                             lookup_gnt_i,
  output logic [AddrWidth-1:0]             lookup_addr_o,
  output ccu_snoop_pkg::snoop_lookup_op_e  lookup_op_o,
  input  logic                             lookup_valid_i,
  input  logic                             lookup_hit_i,
  input  logic                             lookup_dirty_i,
  input  logic                             lookup_shared_i,
  input  logic [DcacheLineWidth-1:0]       lookup_data_i,
  output logic                             busy_o
);

  import ccu_snoop_pkg::*;

  localparam int unsigned DcacheLineWords = DcacheLineWidth / AxiDataWidth;
  localparam int unsigned BeatBits        = $clog2(DcacheLineWords);
  localparam int unsigned OffsetBits      = $clog2(DcacheLineWidth / 8);
  localparam logic [AddrWidth-1:0] AlignMask = {AddrWidth{1'b1}} << OffsetBits;

  typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_RESP, SEND_CR, SEND_CD} state_e;

  state_e               state_reg, state_next;
  logic                 started_reg;
  logic [AddrWidth-1:0] addr_reg;
  logic [3:0]           snoop_reg;
  snoop_lookup_op_e     op_reg;
  logic [4:0]           cr_reg;

  logic                 ac_ready, ac_hs;
  logic                 cr_valid, cd_valid;
  logic [3:0]           dec_snoop;
  snoop_decode_t        dec;

  logic                    ser_in_valid, ser_in_ready;
  logic                    ser_out_valid, ser_out_ready, ser_last;
  logic [AxiDataWidth-1:0] ser_data;

  // One decoder serves both the AC opcode in IDLE and the lookup result later.
  assign dec_snoop = (state_reg == IDLE) ? snoop_req_i.ac.snoop : snoop_reg;
  assign dec       = decode_snoop(dec_snoop, lookup_hit_i, lookup_dirty_i, lookup_shared_i);

  // started_reg keeps ac_ready low until the first clock after reset release.
  assign ac_ready = (state_reg == IDLE) && started_reg;
  assign ac_hs    = ac_ready && snoop_req_i.ac_valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      started_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      started_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_reg  <= '0;
      snoop_reg <= '0;
      op_reg    <= KEEP;
      cr_reg    <= '0;
    end else begin
      if (ac_hs) begin
        addr_reg  <= snoop_req_i.ac.addr & AlignMask;
        snoop_reg <= snoop_req_i.ac.snoop;
        op_reg    <= dec.op;
        if (!dec.supported) cr_reg <= dec.cr_resp;
      end
      if (state_reg == WAIT_RESP && lookup_valid_i) cr_reg <= dec.cr_resp;
    end
  end

  always_comb begin
    state_next    = state_reg;
    lookup_req_o  = 1'b0;
    cr_valid      = 1'b0;
    cd_valid      = 1'b0;
    ser_in_valid  = 1'b0;
    ser_out_ready = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ac_hs) state_next = dec.supported ? LOOKUP : SEND_CR;
      end
      LOOKUP: begin
        lookup_req_o = 1'b1;
        if (lookup_gnt_i) state_next = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (lookup_valid_i) begin
          ser_in_valid = dec.cr_resp[CR_DT] && ser_in_ready;
          state_next   = SEND_CR;
        end
      end
      SEND_CR: begin
        cr_valid = 1'b1;
        if (snoop_req_i.cr_ready) state_next = cr_reg[CR_DT] ? SEND_CD : IDLE;
      end
      SEND_CD: begin
        cd_valid      = ser_out_valid;
        ser_out_ready = snoop_req_i.cd_ready;
        if (ser_out_valid && snoop_req_i.cd_ready && ser_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  snoop_cd_serializer #(
    .BeatWidth (AxiDataWidth),
    .Words     (DcacheLineWords),
    .BeatBits  (BeatBits)
  ) u_cd_serializer (
    .clk       (clk_i),
    .rst       (rst_i),
    .in_valid  (ser_in_valid),
    .in_ready  (ser_in_ready),
    .in_data   (lookup_data_i),
    .out_valid (ser_out_valid),
    .out_ready (ser_out_ready),
    .out_data  (ser_data),
    .out_last  (ser_last)
  );

  assign lookup_addr_o = addr_reg;
  assign lookup_op_o   = op_reg;
  assign busy_o        = (state_reg != IDLE);

  always_comb begin
    snoop_resp_o          = '0;
    snoop_resp_o.ac_ready = ac_ready;
    snoop_resp_o.cr_valid = cr_valid;
    snoop_resp_o.cr_resp  = cr_reg;
    snoop_resp_o.cd_valid = cd_valid;
    snoop_resp_o.cd.data  = ser_data;
    snoop_resp_o.cd.last  = ser_last && cd_valid;
  end

endmodule

// File: tb/tb_ccu_snoop_responder.sv
// Directed and randomized checks of ccu_snoop_responder against a
// rule-level model of the snoop response table.
module tb_ccu_snoop_responder;
  import ccu_snoop_pkg::*;

  logic             clk, rst;
  snoop_req_t       req;
  snoop_resp_t      resp;
  logic             lookup_req, lookup_gnt, lookup_valid;
  logic             hit, dirty, shared, busy;
  logic [63:0]      lookup_addr;
  snoop_lookup_op_e lookup_op;
  logic [127:0]     lookup_data;

  int vectors = 0;
  int miscompares = 0;

  ccu_snoop_responder dut (
    .clk_i(clk), .rst_i(rst), .snoop_req_i(req), .snoop_resp_o(resp),
    .lookup_req_o(lookup_req), .lookup_gnt_i(lookup_gnt), .lookup_addr_o(lookup_addr),
    .lookup_op_o(lookup_op), .lookup_valid_i(lookup_valid), .lookup_hit_i(hit),
    .lookup_dirty_i(dirty), .lookup_shared_i(shared), .lookup_data_i(lookup_data),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observations of the last transaction
  bit               obs_timeout, obs_req_seen, obs_end_ready;
  int               obs_req_cyc, obs_cr_cyc, obs_cd_cyc, obs_end_cyc;
  int               obs_hold_err, obs_ready_err;
  snoop_lookup_op_e obs_op;
  logic [63:0]      obs_addr;
  logic [4:0]       obs_cr;
  logic [63:0]      obs_data_q[$];
  bit               obs_last_q[$];

  // Response rules, written from the opcode classes rather than per opcode
  function automatic logic [4:0] model_cr(input logic [3:0] snp, input bit h, input bit d, input bit s);
    bit rd, cl, mi, dt, pd, is;
    rd = snp inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7};
    cl = snp inside {4'd8, 4'd9};
    mi = (snp == 4'd13);
    if (!(rd || cl || mi)) return 5'b00010;
    if (!h) return 5'b00000;
    dt = rd || (cl && d);
    pd = (rd && snp != 4'd0 && d) || (cl && d);
    is = snp inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd8};
    return {!s, is, pd, 1'b0, dt};
  endfunction

  function automatic bit model_supported(input logic [3:0] snp);
    return snp inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd13};
  endfunction

  function automatic snoop_lookup_op_e model_op(input logic [3:0] snp);
    case (snp)
      4'd0:             return KEEP;
      4'd1, 4'd2, 4'd3: return SHARE;
      4'd8:             return CLEAN;
      default:          return INVALIDATE;
    endcase
  endfunction

  // Drives one snoop end to end playing the cache and CCU roles; records what it saw.
  task automatic do_snoop(input logic [3:0] snp, input logic [63:0] addr, input bit hh, input bit dd,
                          input bit ss, input logic [127:0] line, input int gnt_dly, input int val_dly,
                          input int cr_dly, input logic [7:0] cdr_pat, input bit noise, input bit abort_on_cd);
    int cyc, wait_cnt, gcnt, vcnt, crcnt, pidx;
    bit granted_pend, prev_cd_stall, prev_cr_stall;
    logic [63:0] prev_data;
    logic [4:0]  prev_cr;
    obs_timeout = 0; obs_req_seen = 0; obs_end_ready = 0;
    obs_req_cyc = -1; obs_cr_cyc = -1; obs_cd_cyc = -1; obs_end_cyc = -1;
    obs_hold_err = 0; obs_ready_err = 0; obs_cr = 'x; obs_addr = 'x; obs_op = KEEP;
    obs_data_q.delete(); obs_last_q.delete();
    gcnt = 0; vcnt = 0; crcnt = 0; pidx = 0;
    granted_pend = 0; prev_cd_stall = 0; prev_cr_stall = 0; prev_data = '0; prev_cr = '0;
    @(negedge clk);
    req.ac.addr = addr; req.ac.snoop = snp; req.ac_valid = 1'b1;
    wait_cnt = 0;
    while (resp.ac_ready !== 1'b1 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (resp.ac_ready !== 1'b1) begin
      obs_timeout = 1; req.ac_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req.ac_valid = 1'b0; req.ac.addr = {$urandom, $urandom}; req.ac.snoop = 4'($urandom);
    cyc = 1;
    while (cyc < 80) begin
      if (busy !== 1'b1) begin
        obs_end_cyc = cyc; obs_end_ready = resp.ac_ready;
        break;
      end
      if (resp.ac_ready !== 1'b0) obs_ready_err++;
      if (prev_cd_stall && (resp.cd_valid !== 1'b1 || resp.cd.data !== prev_data)) obs_hold_err++;
      if (prev_cr_stall && (resp.cr_valid !== 1'b1 || resp.cr_resp !== prev_cr)) obs_hold_err++;
      lookup_gnt = 1'b0; lookup_valid = 1'b0;
      hit = 1'($urandom); dirty = 1'($urandom); shared = 1'($urandom);
      lookup_data = {$urandom, $urandom, $urandom, $urandom};
      if (granted_pend) begin
        if (vcnt >= val_dly) begin
          lookup_valid = 1'b1; hit = hh; dirty = dd; shared = ss; lookup_data = line;
          granted_pend = 0;
        end else vcnt++;
      end else if (lookup_req === 1'b1) begin
        if (!obs_req_seen) begin
          obs_req_seen = 1; obs_req_cyc = cyc; obs_op = lookup_op; obs_addr = lookup_addr;
        end else if (lookup_op !== obs_op || lookup_addr !== obs_addr) obs_hold_err++;
        if (gcnt >= gnt_dly) begin
          lookup_gnt = 1'b1; granted_pend = 1; vcnt = 0;
        end else begin
          gcnt++;
          if (noise) begin
            lookup_valid = 1'b1; hit = !hh; dirty = !dd; shared = !ss; lookup_data = ~line;
          end
        end
      end
      req.cr_ready = 1'b0;
      if (resp.cr_valid === 1'b1) begin
        if (obs_cr_cyc < 0) begin obs_cr_cyc = cyc; obs_cr = resp.cr_resp; end
        if (crcnt >= cr_dly) req.cr_ready = 1'b1; else crcnt++;
      end
      req.cd_ready = 1'b0;
      if (resp.cd_valid === 1'b1) begin
        if (obs_cd_cyc < 0) obs_cd_cyc = cyc;
        if (abort_on_cd) return;
        req.cd_ready = cdr_pat[pidx % 8];
        pidx++;
        if (req.cd_ready) begin
          obs_data_q.push_back(resp.cd.data);
          obs_last_q.push_back(resp.cd.last);
        end
      end
      prev_cd_stall = (resp.cd_valid === 1'b1) && !req.cd_ready;
      prev_data     = resp.cd.data;
      prev_cr_stall = (resp.cr_valid === 1'b1) && !req.cr_ready;
      prev_cr       = resp.cr_resp;
      @(negedge clk);
      cyc++;
    end
    if (obs_end_cyc < 0) obs_timeout = 1;
    lookup_gnt = 1'b0; lookup_valid = 1'b0; req.cr_ready = 1'b0; req.cd_ready = 1'b0;
  endtask

  task automatic test_reset();
    req = '0; lookup_gnt = 0; lookup_valid = 0; hit = 0; dirty = 0; shared = 0; lookup_data = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({resp.ac_ready, resp.cr_valid, resp.cd_valid, lookup_req, busy} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required 00000",
               {resp.ac_ready, resp.cr_valid, resp.cd_valid, lookup_req, busy});
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (resp.ac_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_release_ready: got %b required 0", resp.ac_ready);
    end
    @(negedge clk);
    vectors++;
    if (resp.ac_ready !== 1'b1) begin
      miscompares++; $display("FAIL ready_after_reset: got %b required 1", resp.ac_ready);
    end
  endtask

  task automatic test_read_shared();
    logic [127:0] line = {$urandom, $urandom, $urandom, $urandom};
    logic [63:0]  addr = {$urandom, $urandom} | 64'h3f;
    do_snoop(SNP_READ_SHARED, addr, 1, 1, 0, line, 0, 0, 0, 8'hff, 0, 0);
    $display("txn read_shared cr=%b beats=%0d", obs_cr, obs_data_q.size());
    vectors++;
    if (obs_timeout || obs_op !== SHARE || obs_addr !== (addr & ~64'hf)) begin
      miscompares++;
      $display("FAIL rs_lookup: timeout=%0d op=%0d addr=%h required op=1 addr=%h",
               obs_timeout, obs_op, obs_addr, addr & ~64'hf);
    end
    vectors++;
    if (obs_cr !== 5'b11101) begin
      miscompares++; $display("FAIL rs_cr: got %b required 11101", obs_cr);
    end
    vectors++;
    if (obs_data_q.size() != 2 || obs_data_q[0] !== line[63:0] || obs_data_q[1] !== line[127:64]
        || obs_last_q[0] != 0 || obs_last_q[1] != 1) begin
      miscompares++;
      $display("FAIL rs_beats: count=%0d beat0=%h beat1=%h required %h %h with last on beat 1",
               obs_data_q.size(), obs_data_q.size() > 0 ? obs_data_q[0] : 64'h0,
               obs_data_q.size() > 1 ? obs_data_q[1] : 64'h0, line[63:0], line[127:64]);
    end
    vectors++;
    if (obs_req_cyc != 1 || obs_cr_cyc != 3 || obs_cd_cyc != 4 || obs_end_cyc != 6 || !obs_end_ready) begin
      miscompares++;
      $display("FAIL rs_latency: req=%0d cr=%0d cd=%0d idle=%0d ready=%0d required 1 3 4 6 1",
               obs_req_cyc, obs_cr_cyc, obs_cd_cyc, obs_end_cyc, obs_end_ready);
    end
  endtask

  task automatic test_make_invalid();
    do_snoop(SNP_MAKE_INVALID, {$urandom, $urandom}, 1, 1, 0, {4{$urandom}}, 1, 1, 1, 8'hff, 1, 0);
    $display("txn make_invalid cr=%b cd_first=%0d", obs_cr, obs_cd_cyc);
    vectors++;
    if (obs_timeout || obs_op !== INVALIDATE || obs_cr !== 5'b10000 || obs_cd_cyc != -1) begin
      miscompares++;
      $display("FAIL mi_resp: op=%0d cr=%b cd_first=%0d required op=3 cr=10000 no cd",
               obs_op, obs_cr, obs_cd_cyc);
    end
  endtask

  task automatic test_read_unique_miss();
    do_snoop(SNP_READ_UNIQUE, {$urandom, $urandom}, 0, 1, 0, {4{$urandom}}, 0, 0, 0, 8'hff, 0, 0);
    $display("txn read_unique_miss cr=%b idle_at=%0d", obs_cr, obs_end_cyc);
    vectors++;
    if (obs_cr !== 5'b00000 || obs_cd_cyc != -1 || obs_end_cyc != 4) begin
      miscompares++;
      $display("FAIL ru_miss: cr=%b cd_first=%0d idle_at=%0d required 00000 no cd 4",
               obs_cr, obs_cd_cyc, obs_end_cyc);
    end
  endtask

  task automatic test_unsupported();
    logic [127:0] line = {$urandom, $urandom, $urandom, $urandom};
    do_snoop(4'b0110, {$urandom, $urandom}, 1, 1, 0, line, 0, 0, 0, 8'hff, 0, 0);
    $display("txn unsupported cr=%b lookup=%0d", obs_cr, obs_req_seen);
    vectors++;
    if (obs_req_seen || obs_cr !== 5'b00010 || obs_end_cyc != 2) begin
      miscompares++;
      $display("FAIL unsup: lookup=%0d cr=%b idle_at=%0d required 0 00010 2",
               obs_req_seen, obs_cr, obs_end_cyc);
    end
    do_snoop(SNP_READ_ONCE, {$urandom, $urandom}, 1, 0, 0, line, 0, 0, 0, 8'hff, 0, 0);
    $display("txn read_once_after_unsup cr=%b beats=%0d", obs_cr, obs_data_q.size());
    vectors++;
    if (obs_timeout || obs_op !== KEEP || obs_cr !== 5'b11001 || obs_data_q.size() != 2) begin
      miscompares++;
      $display("FAIL unsup_next: timeout=%0d op=%0d cr=%b beats=%0d required 0 0 11001 2",
               obs_timeout, obs_op, obs_cr, obs_data_q.size());
    end
  endtask

  task automatic test_clean_shared_backpressure();
    logic [127:0] line = {$urandom, $urandom, $urandom, $urandom};
    do_snoop(SNP_CLEAN_SHARED, {$urandom, $urandom}, 1, 1, 0, line, 0, 0, 0, 8'b0000_1001, 0, 0);
    $display("txn clean_shared_bp cr=%b beats=%0d", obs_cr, obs_data_q.size());
    vectors++;
    if (obs_op !== CLEAN || obs_cr !== 5'b11101) begin
      miscompares++; $display("FAIL cs_resp: op=%0d cr=%b required 2 11101", obs_op, obs_cr);
    end
    vectors++;
    if (obs_hold_err != 0 || obs_data_q.size() != 2 || obs_data_q[0] !== line[63:0]
        || obs_data_q[1] !== line[127:64]) begin
      miscompares++;
      $display("FAIL cs_stall: hold_errors=%0d beats=%0d required 0 errors 2 beats",
               obs_hold_err, obs_data_q.size());
    end
  endtask

  task automatic test_reset_mid_cd();
    logic [127:0] line = {$urandom, $urandom, $urandom, $urandom};
    do_snoop(SNP_READ_SHARED, {$urandom, $urandom}, 1, 0, 0, {4{$urandom}}, 0, 0, 0, 8'h00, 0, 1);
    rst = 1'b1;
    #1;
    vectors++;
    if ({resp.cr_valid, resp.cd_valid, lookup_req, resp.ac_ready, busy} !== 5'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got %b required 00000",
               {resp.cr_valid, resp.cd_valid, lookup_req, resp.ac_ready, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    do_snoop(SNP_READ_ONCE, {$urandom, $urandom}, 1, 0, 1, line, 0, 0, 0, 8'hff, 0, 0);
    $display("txn read_once_after_reset cr=%b beats=%0d", obs_cr, obs_data_q.size());
    vectors++;
    if (obs_timeout || obs_cr !== 5'b01001 || obs_data_q.size() != 2 || obs_data_q[0] !== line[63:0]
        || obs_data_q[1] !== line[127:64]) begin
      miscompares++;
      $display("FAIL post_reset_txn: timeout=%0d cr=%b beats=%0d required 01001 low-then-high",
               obs_timeout, obs_cr, obs_data_q.size());
    end
  endtask

  task automatic test_random();
    logic [3:0]   list [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd13};
    logic [3:0]   snp;
    logic [63:0]  addr;
    logic [127:0] line;
    logic [4:0]   exp_cr;
    bit           hh, dd, ss, sup;
    int           exp_beats;
    for (int t = 0; t < 40; t++) begin
      snp  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : list[$urandom_range(0, 7)];
      hh   = 1'($urandom); dd = 1'($urandom); ss = 1'($urandom);
      addr = {$urandom, $urandom};
      line = {$urandom, $urandom, $urandom, $urandom};
      do_snoop(snp, addr, hh, dd, ss, line, $urandom_range(0, 2), $urandom_range(0, 2),
               $urandom_range(0, 2), 8'($urandom_range(1, 255)), 1'($urandom), 0);
      exp_cr    = model_cr(snp, hh, dd, ss);
      sup       = model_supported(snp);
      exp_beats = exp_cr[0] ? 2 : 0;
      $display("txn %0d snoop=%b hit=%0d dirty=%0d shared=%0d cr=%b beats=%0d",
               t, snp, hh, dd, ss, obs_cr, obs_data_q.size());
      vectors++;
      if (obs_timeout || obs_cr !== exp_cr) begin
        miscompares++;
        $display("FAIL rnd_cr[%0d]: timeout=%0d cr=%b required %b", t, obs_timeout, obs_cr, exp_cr);
      end
      vectors++;
      if (obs_req_seen != sup || (sup && (obs_op !== model_op(snp) || obs_addr !== (addr & ~64'hf)))) begin
        miscompares++;
        $display("FAIL rnd_lookup[%0d]: seen=%0d op=%0d addr=%h required %0d %0d %h",
                 t, obs_req_seen, obs_op, obs_addr, sup, model_op(snp), addr & ~64'hf);
      end
      vectors++;
      if (obs_data_q.size() != exp_beats || obs_hold_err != 0 || obs_ready_err != 0) begin
        miscompares++;
        $display("FAIL rnd_cd[%0d]: beats=%0d hold_errors=%0d ready_errors=%0d required %0d 0 0",
                 t, obs_data_q.size(), obs_hold_err, obs_ready_err, exp_beats);
      end
      for (int i = 0; i < obs_data_q.size() && i < exp_beats; i++) begin
        vectors++;
        if (obs_data_q[i] !== line[i*64 +: 64] || obs_last_q[i] != (i == exp_beats - 1)) begin
          miscompares++;
          $display("FAIL rnd_beat[%0d.%0d]: data=%h last=%0d required %h %0d",
                   t, i, obs_data_q[i], obs_last_q[i], line[i*64 +: 64], i == exp_beats - 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_shared();
    test_make_invalid();
    test_read_unique_miss();
    test_unsupported();
    test_clean_shared_backpressure();
    test_reset_mid_cd();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
